demux1to4_reg: RTL and testbench
================================

# demux1to4_reg

Registered 1-to-4 demultiplexer: the write-direction counterpart of the datapath's 4-to-1 result selectors. Takes one `bit_size`-bit word per accepted transfer and steers it, by a 2-bit select, into one of four single-entry output buffers. Each buffer has its own valid/ready handshake, so a stalled destination never blocks the other three. It sits between a shared producer (e.g. write-back bus) and four independent consumers.

## Interface
- `bit_size`, 32, data width of input and every output channel

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  bit_size  word to route
- `in_valid`  in  1  producer offers `in_data`/`S` this cycle
- `in_ready`  out  1  block accepts this cycle (combinational)
- `S`  in  2  destination channel 0..3, sampled only when `in_valid`=1
- `O0`..`O3`  out  bit_size each  buffered data of channel k
- `out_valid`  out  4  bit k = channel k buffer holds a word
- `out_ready`  in  4  bit k = consumer k takes the word this cycle
- `busy`  out  1  OR of `out_valid`
- `xfer_cnt`  out  32  four packed 8-bit per-channel accept counters, channel k in bits [8k+7:8k]; present only with `DEMUX_XFER_CNT_EN`

## Operation
- Per channel k: one buffer register `Ok` plus flag `out_valid[k]`; no other state.
- `in_ready = ~out_valid[S] | out_ready[S]`. Depends only on the selected channel; other channels' state is ignored.
- Accept = `in_valid & in_ready`. On accept: `O[S] <= in_data`, `out_valid[S] <= 1` next edge.
- Drain of k = `out_valid[k] & out_ready[k]`. On drain without a simultaneous accept into k: `out_valid[k] <= 0`; `Ok` holds its last value (not cleared).
- Simultaneous drain and accept on the same channel: new word loaded, `out_valid[k]` stays 1 (full throughput, one word/cycle).
- Accept into channel j and drain of channel k≠j in the same cycle are independent; both take effect.
- While `out_valid[k]`=1 and `out_ready[k]`=0: `Ok` is stable.
- `out_ready[k]` while `out_valid[k]`=0: ignored.
- `S` and `in_data` are don't-care when `in_valid`=0; `in_ready` is still driven from the current `S`.
- Producer must not depend on `in_ready` to drive `in_valid` (no combinational loop created by the block).

## Timing
- Reset (any cycle, including mid-transfer): `out_valid`=4'b0000, `O0`..`O3`=0, `busy`=0, `xfer_cnt`=0. An accept in the reset cycle is dropped.
- Latency: accept at edge N → `out_valid[S]`=1 and data on `O[S]` after edge N (visible in cycle N+1).
- `in_ready` is combinational from `S`, `out_valid`, and `out_ready`, with no register stage.
- `busy` is combinational from the registered `out_valid`.
- Throughput: 1 word/cycle to a single channel that is always ready; 1 word/cycle overall when rotating across channels.

## Configuration
- `DEMUX_XFER_CNT_EN` defined: `xfer_cnt` port and four 8-bit counters exist. Counter k increments by 1 on each accept with `S`=k. Wraps 255→0. Cleared by `rst`. Drains do not count.
- Not defined: the port and the counters are absent. All other behaviour is identical.

## Test plan
- Reset: assert `rst` 2 cycles with `in_valid`=1, `S`=2, `in_data`=32'hDEAD_BEEF → `out_valid`=0000, `O2`=0 after release, `busy`=0.
- Basic route: `out_ready`=1111; send 32'h11, 32'h22, 32'h33, 32'h44 with `S`=0,1,2,3 on consecutive cycles → each appears one cycle later on `O0`..`O3`, `out_valid` pulses 0001, 0010, 0100, 1000.
- Backpressure isolation: `out_ready[1]`=0; send 32'hA5 to `S`=1, then 32'h5A to `S`=1 → second transfer sees `in_ready`=0 and `O1` stays 32'hA5. Meanwhile a transfer of 32'h77 to `S`=3 is accepted and appears on `O3`. Raise `out_ready[1]` → 32'h5A is accepted the same cycle and `out_valid[1]` stays 1.
- Same-channel streaming: `out_ready[0]`=1; 8 back-to-back words 0..7 to `S`=0 → `in_ready` is 1 every cycle and `O0` shows 0..7 in order, each one cycle after its accept.
- Reset mid-operation: all four buffers full with `out_ready`=0000, assert `rst` → next cycle `out_valid`=0000, all outputs 0, `in_ready`=1 for every `S`.
- With `DEMUX_XFER_CNT_EN`: 257 accepts to `S`=2 plus 3 accepts to `S`=0 → `xfer_cnt`=32'h0001_0003 (channel 2 wrapped to 1, channel 0 = 3).

Source files
------------

// File: rtl/demux1to4_reg.sv
// demux1to4_reg: registered 1-to-4 demultiplexer with per-channel
// single-entry buffers and independent valid/ready handshakes.
// Optional build macro DEMUX_XFER_CNT_EN adds four 8-bit accept
// counters exposed on xfer_cnt.

// One channel buffer: loads on accept, clears valid on drain.
module demux1to4_reg_chan #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_ld,
    input  logic [W-1:0] i_data,
    input  logic         i_rdy,
    output logic [W-1:0] o_data,
    output logic         o_vld
);
    logic [W-1:0] r_data;
    logic         r_vld;

    // Load wins over drain so a same-cycle drain+accept keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else if (i_ld) begin
            r_data <= i_data;
            r_vld  <= 1'b1;
        end else if (r_vld && i_rdy) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;
endmodule

module demux1to4_reg #(
    parameter int bit_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [bit_size-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          S,
    output logic [bit_size-1:0] O0,
    output logic [bit_size-1:0] O1,
    output logic [bit_size-1:0] O2,
    output logic [bit_size-1:0] O3,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
`ifdef DEMUX_XFER_CNT_EN
    output logic [31:0]         xfer_cnt,
`endif
    output logic                busy
);
    localparam int NUM_CH = 4;

    logic [NUM_CH-1:0][bit_size-1:0] w_data;
    logic [NUM_CH-1:0]               w_ld;
    logic                            w_acc;

    // Ready only looks at the selected channel; others never stall the producer.
    assign in_ready = ~out_valid[S] | out_ready[S];
    assign w_acc    = in_valid & in_ready;
    assign busy     = |out_valid;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_ld[k] = w_acc && (S == k[1:0]);

        demux1to4_reg_chan #(.W(bit_size)) u_chan (
            .clk    (clk),
            .rst    (rst),
            .i_ld   (w_ld[k]),
            .i_data (in_data),
            .i_rdy  (out_ready[k]),
            .o_data (w_data[k]),
            .o_vld  (out_valid[k])
        );
    end

    assign O0 = w_data[0];
    assign O1 = w_data[1];
    assign O2 = w_data[2];
    assign O3 = w_data[3];

`ifdef DEMUX_XFER_CNT_EN
    logic [NUM_CH-1:0][7:0] r_cnt;

    // Per-channel accept counters; 8-bit wrap is intended.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_ld[k]) r_cnt[k] <= r_cnt[k] + 8'd1;
            end
        end
    end

    assign xfer_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_demux1to4_reg.sv
// Self-checking bench for demux1to4_reg: directed plan steps followed by
// random traffic, all checked against a behavioural array model.
module tb_demux1to4_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  S;
    logic [31:0] O0, O1, O2, O3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        busy;
`ifdef DEMUX_XFER_CNT_EN
    logic [31:0] xfer_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: contents/occupancy of each buffer and accept counts.
    logic [31:0] m_data [4];
    bit          m_full [4];
    int          m_cnt  [4];
    bit          chk_en = 0;

    always #5 clk = ~clk;

    demux1to4_reg #(.bit_size(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .O0        (O0),
        .O1        (O1),
        .O2        (O2),
        .O3        (O3),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DEMUX_XFER_CNT_EN
        .xfer_cnt  (xfer_cnt),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_o(input int k);
        case (k)
            0: return O0;
            1: return O1;
            2: return O2;
            default: return O3;
        endcase
    endfunction

    // Compare every output against the model's current state.
    task automatic check_all();
        logic [3:0]  ev;
        logic [31:0] ec;
        for (int k = 0; k < 4; k++) begin
            ev[k] = m_full[k];
            check($sformatf("O%0d", k), dut_o(k), m_data[k]);
        end
        check("out_valid", {28'd0, out_valid}, {28'd0, ev});
        check("busy", {31'd0, busy}, {31'd0, (ev != 4'd0)});
        check("in_ready", {31'd0, in_ready}, {31'd0, (!m_full[S] || out_ready[S])});
`ifdef DEMUX_XFER_CNT_EN
        ec = {m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]};
        check("xfer_cnt", xfer_cnt, ec);
`else
        ec = 32'd0;
`endif
    endtask

    // One clock: drive, check pre-edge outputs, advance model, take edge.
    task automatic cyc(input logic r, input logic v, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] rdy);
        bit acc;
        rst = r; in_valid = v; S = s; in_data = d; out_ready = rdy;
        #1;
        if (chk_en) check_all();
        acc = v && (!m_full[s] || rdy[s]);
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                m_data[k] = 32'd0; m_full[k] = 0; m_cnt[k] = 0;
            end else if (acc && s == k) begin
                m_data[k] = d; m_full[k] = 1; m_cnt[k] = (m_cnt[k] + 1) % 256;
            end else if (m_full[k] && rdy[k]) begin
                m_full[k] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; S = 2'd0; in_data = 32'd0; out_ready = 4'd0;
        @(posedge clk);
        #1;

        // Reset with an accept offered during reset: it must be dropped.
        cyc(1, 1, 2, 32'hDEAD_BEEF, 4'b0000);
        chk_en = 1;
        cyc(1, 1, 2, 32'hDEAD_BEEF, 4'b0000);
        check("rst_valid", {28'd0, out_valid}, 32'd0);
        check("rst_O2", O2, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Basic route, all consumers ready.
        cyc(0, 1, 0, 32'h11, 4'b1111);
        check("route_v0", {28'd0, out_valid}, 32'h1);
        cyc(0, 1, 1, 32'h22, 4'b1111);
        check("route_v1", {28'd0, out_valid}, 32'h2);
        cyc(0, 1, 2, 32'h33, 4'b1111);
        check("route_v2", {28'd0, out_valid}, 32'h4);
        cyc(0, 1, 3, 32'h44, 4'b1111);
        check("route_v3", {28'd0, out_valid}, 32'h8);
        check("route_O3", O3, 32'h44);
        cyc(0, 0, 0, 32'h0, 4'b1111);

        // Backpressure isolation on channel 1.
        cyc(0, 1, 1, 32'hA5, 4'b1101);
        cyc(0, 1, 1, 32'h5A, 4'b1101);
        check("bp_O1_hold", O1, 32'hA5);
        cyc(0, 1, 3, 32'h77, 4'b1101);
        check("bp_O3", O3, 32'h77);
        check("bp_O1_still", O1, 32'hA5);
        cyc(0, 1, 1, 32'h5A, 4'b1111);
        check("bp_O1_new", O1, 32'h5A);
        check("bp_v1", {31'd0, out_valid[1]}, 32'd1);
        cyc(0, 0, 0, 32'h0, 4'b1111);

        // Same-channel streaming.
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, i, 4'b1111);
            check("stream_O0", O0, i);
        end
        cyc(0, 0, 0, 32'h0, 4'b1111);

        // Fill all buffers, then reset mid-operation.
        for (int k = 0; k < 4; k++) cyc(0, 1, k[1:0], 32'hC0 + k, 4'b0000);
        check("full_valid", {28'd0, out_valid}, 32'hF);
        cyc(1, 0, 0, 32'h0, 4'b0000);
        check("mid_rst_valid", {28'd0, out_valid}, 32'd0);
        for (int k = 0; k < 4; k++) cyc(0, 0, k[1:0], 32'h0, 4'b0000);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom, $urandom_range(0, 15));
        end

`ifdef DEMUX_XFER_CNT_EN
        // Counter wrap on channel 2 plus three accepts on channel 0.
        cyc(1, 0, 0, 32'h0, 4'b1111);
        for (int i = 0; i < 257; i++) cyc(0, 1, 2, i, 4'b1111);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, i, 4'b1111);
        cyc(0, 0, 0, 32'h0, 4'b1111);
        check("cnt_wrap", xfer_cnt, 32'h0001_0003);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
